host_multi_queue_schedule: RTL and testbench
============================================

Name: host_multi_queue_schedule

Overview:
Parametrised successor to the host output scheduler. It holds NUM_NTS_QUEUE non-TS descriptor FIFOs. It arbitrates between one TS descriptor stream and those queues and issues one descriptor at a time to host_tx whenever the host outport is free. Arbitration is selectable between strict priority and round-robin. Position: between host_input_queue/ts_submit_management (upstream) and host_tx (downstream), inside host_transmit_process.

Parameters:
DESC_W, 13, descriptor width (bufid + type/inport bits)
NUM_NTS_QUEUE, 4, number of NTS queues (2..8; need not be a power of 2)
QID_W, 3, width of queue-id input (>= clog2(NUM_NTS_QUEUE))
FIFO_AW, 4, per-queue FIFO address width; depth = 2**FIFO_AW

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
iv_sched_mode  in  1  0 = strict priority (queue 0 highest), 1 = round-robin
iv_nts_descriptor  in  DESC_W  NTS descriptor to enqueue
iv_nts_queue_id  in  QID_W  target queue
i_nts_descriptor_wr  in  1  enqueue strobe, 1 cycle per descriptor
iv_ts_descriptor  in  DESC_W  TS descriptor, held stable while i_ts_descriptor_wr = 1
i_ts_descriptor_wr  in  1  TS valid level; held until ack
o_ts_descriptor_ack  out  1  1-cycle pulse, TS descriptor consumed
i_host_outport_free  in  1  host_tx ready for a descriptor
ov_descriptor  out  DESC_W  descriptor to host_tx
o_descriptor_wr  out  1  1-cycle issue strobe
ov_queue_empty  out  NUM_NTS_QUEUE  per-queue empty flags
ov_queue_full  out  NUM_NTS_QUEUE  per-queue full flags
o_nts_discard_pulse  out  1  enqueue dropped (full queue or invalid id)
hms_state  out  2  FSM state for debug

Behaviour:
- Reset values:
  - All outputs 0, except ov_queue_empty = all 1s.
  - FIFO pointers and counts 0; RR pointer 0; FSM in IDLE.
  - Reset mid-operation flushes every queued descriptor; a pending TS request is not acked.
- Enqueue:
  - When i_nts_descriptor_wr = 1, the descriptor is written to queue iv_nts_queue_id.
  - Full is evaluated before any same-cycle pop. A write to a queue that is full in that cycle is dropped, even if a pop occurs in the same cycle.
  - Queue id >= NUM_NTS_QUEUE is dropped.
  - Every drop produces o_nts_discard_pulse 1 cycle later.
  - Simultaneous push and pop on a non-full, non-empty queue: count unchanged.
  - Count width FIFO_AW+1; pointers wrap modulo 2**FIFO_AW.
  - Flags are registered and reflect the count after the edge.
- FSM states: IDLE (0), NTS_RD (1), HOLD (2); encoding 3 unused and recovers to IDLE.
- IDLE, when i_host_outport_free = 1:
  - If i_ts_descriptor_wr = 1: ov_descriptor <= TS descriptor; o_descriptor_wr and o_ts_descriptor_ack pulse together on the next cycle; go to HOLD. TS always wins over NTS.
  - Else, if any queue is non-empty: select a queue and pop it (FIFO RAM read latency 1); go to NTS_RD.
  - Strict-priority selection: the lowest non-empty index.
  - Round-robin selection: the first non-empty index at or after rr_ptr, searching modulo NUM_NTS_QUEUE. rr_ptr <= (sel + 1) mod NUM_NTS_QUEUE. rr_ptr is updated only in round-robin mode.
  - iv_sched_mode is sampled only at IDLE arbitration.
- NTS_RD: register the RAM output into ov_descriptor and assert o_descriptor_wr for 1 cycle; go to HOLD.
- HOLD: one-cycle holdoff so that host_tx can deassert free; i_host_outport_free is ignored; next state IDLE.
- Latency:
  - TS: 1 cycle from IDLE with free = 1 to o_descriptor_wr.
  - NTS: 2 cycles.
  - Minimum issue interval: 3 cycles.
- Ordering: FIFO order within each queue.
- No issue occurs while i_host_outport_free = 0; queued data is retained indefinitely.

Decomposition:
- Shared package: DESC_W default, FSM state encodings, mode encodings.
- One sub-module: hms_desc_fifo (single-clock, DESC_W x 2**FIFO_AW, registered read, count/full/empty flags), instantiated NUM_NTS_QUEUE times via a generate loop.
- The arbiter (priority/RR find-first) is a function inside the top module.

Test Plan:
- Basic NTS issue: reset; enqueue 0x0A5 to q2; free = 1 → o_descriptor_wr with ov_descriptor = 0x0A5 exactly 2 cycles after IDLE sampling; ov_queue_empty returns to 4'b1111.
- TS priority: q0 holds 0x001 and TS 0x1FF is held, free = 1 → 0x1FF issued first with ack; 0x001 issued 3 cycles later.
- Round-robin: mode = 1; q0, q1, q3 each hold 2 descriptors; free held = 1 → issue order q0, q1, q3, q0, q1, q3.
- Strict priority: mode = 0, same load → issue order q0, q0, q1, q1, q3, q3.
- Full queue and invalid id: write 17 descriptors to q1 with free = 0 → ov_queue_full[1] = 1 after the 16th write, one discard pulse for the 17th; write with id 5 → discard pulse, no state change.
- Reset mid-operation: assert i_rst_n = 0 in NTS_RD → outputs 0 immediately, all queues empty; after release, no descriptor is issued.

Source files
------------

// File: rtl/host_multi_queue_schedule_pkg.sv
// Shared definitions for the host multi-queue scheduler: default widths,
// FSM state encodings and arbitration mode encodings.
package host_multi_queue_schedule_pkg;

  localparam int HMS_DESC_W_DEF = 13;

  typedef enum logic [1:0] {
    HMS_IDLE   = 2'd0,
    HMS_NTS_RD = 2'd1,
    HMS_HOLD   = 2'd2
  } hms_state_e;

  localparam logic HMS_MODE_SP = 1'b0;
  localparam logic HMS_MODE_RR = 1'b1;

endpackage

// File: rtl/host_multi_queue_schedule_if.sv
// Descriptor enqueue / TS request / host_tx issue bundle of the scheduler.
// master = upstream + host_tx side, slave = the scheduler itself.
interface host_multi_queue_schedule_if #(
  parameter int DESC_W        = host_multi_queue_schedule_pkg::HMS_DESC_W_DEF,
  parameter int NUM_NTS_QUEUE = 4,
  parameter int QID_W         = 3
);

  logic                     iv_sched_mode;
  logic [DESC_W-1:0]        iv_nts_descriptor;
  logic [QID_W-1:0]         iv_nts_queue_id;
  logic                     i_nts_descriptor_wr;
  logic [DESC_W-1:0]        iv_ts_descriptor;
  logic                     i_ts_descriptor_wr;
  logic                     o_ts_descriptor_ack;
  logic                     i_host_outport_free;
  logic [DESC_W-1:0]        ov_descriptor;
  logic                     o_descriptor_wr;
  logic [NUM_NTS_QUEUE-1:0] ov_queue_empty;
  logic [NUM_NTS_QUEUE-1:0] ov_queue_full;
  logic                     o_nts_discard_pulse;
  logic [1:0]               hms_state;

  modport master (
    output iv_sched_mode, iv_nts_descriptor, iv_nts_queue_id, i_nts_descriptor_wr,
    output iv_ts_descriptor, i_ts_descriptor_wr, i_host_outport_free,
    input  o_ts_descriptor_ack, ov_descriptor, o_descriptor_wr,
    input  ov_queue_empty, ov_queue_full, o_nts_discard_pulse, hms_state
  );

  modport slave (
    input  iv_sched_mode, iv_nts_descriptor, iv_nts_queue_id, i_nts_descriptor_wr,
    input  iv_ts_descriptor, i_ts_descriptor_wr, i_host_outport_free,
    output o_ts_descriptor_ack, ov_descriptor, o_descriptor_wr,
    output ov_queue_empty, ov_queue_full, o_nts_discard_pulse, hms_state
  );

endinterface

// File: rtl/hms_desc_fifo.sv
// Single-clock descriptor FIFO with registered RAM read and registered
// empty/full flags that reflect the occupancy after each edge.
module hms_desc_fifo #(
  parameter int DW = 13,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] rd_data_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          do_push, do_pop;

  // Full is judged on the pre-edge flag, so a same-cycle pop never rescues a push.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage is left unreset so it maps onto block RAM; pointers alone define contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    if (do_pop)  rd_data_q <= mem_q[rd_ptr_q];
  end

  assign rd_data_o = rd_data_q;
  assign empty_o   = empty_q;
  assign full_o    = full_q;

endmodule

// File: rtl/host_multi_queue_schedule.sv
// Host output scheduler: one TS descriptor stream plus NUM_NTS_QUEUE NTS FIFOs,
// arbitrated by strict priority or round-robin, one issue per host_tx free slot.
module host_multi_queue_schedule
  import host_multi_queue_schedule_pkg::*;
#(
  parameter int DESC_W        = HMS_DESC_W_DEF,
  parameter int NUM_NTS_QUEUE = 4,
  parameter int QID_W         = 3,
  parameter int FIFO_AW       = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  host_multi_queue_schedule_if.slave   bus
);

  localparam int SEL_W = (NUM_NTS_QUEUE > 1) ? $clog2(NUM_NTS_QUEUE) : 1;

  hms_state_e               state_q, state_d;
  logic [NUM_NTS_QUEUE-1:0] empty_w, full_w, push_w, pop_w, nonempty_w;
  logic [DESC_W-1:0]        fifo_rdata_w [NUM_NTS_QUEUE];
  logic [DESC_W-1:0]        desc_q, desc_d;
  logic                     wr_q, wr_d, ack_q, ack_d, discard_q, discard_d;
  logic [SEL_W-1:0]         sel_q, sel_d, rr_q, rr_d, arb_start, arb_sel;

  // First non-empty queue at or after start, searching modulo NUM_NTS_QUEUE.
  function automatic logic [SEL_W-1:0] find_first(
    input logic [NUM_NTS_QUEUE-1:0] req,
    input logic [SEL_W-1:0]         start
  );
    logic [SEL_W-1:0] res;
    logic             found;
    int               idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_NTS_QUEUE; i++) begin
      idx = int'(start) + i;
      if (idx >= NUM_NTS_QUEUE) idx = idx - NUM_NTS_QUEUE;
      if (!found && req[SEL_W'(idx)]) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] sel);
    int n;
    n = int'(sel) + 1;
    return (n >= NUM_NTS_QUEUE) ? '0 : SEL_W'(n);
  endfunction

  for (genvar gi = 0; gi < NUM_NTS_QUEUE; gi++) begin : g_queue
    assign push_w[gi] = bus.i_nts_descriptor_wr &&
                        (bus.iv_nts_queue_id == QID_W'(gi)) && !full_w[gi];

    hms_desc_fifo #(
      .DW (DESC_W),
      .AW (FIFO_AW)
    ) u_fifo (
      .clk_i     (i_clk),
      .rst_n_i   (i_rst_n),
      .push_i    (push_w[gi]),
      .wr_data_i (bus.iv_nts_descriptor),
      .pop_i     (pop_w[gi]),
      .rd_data_o (fifo_rdata_w[gi]),
      .empty_o   (empty_w[gi]),
      .full_o    (full_w[gi])
    );
  end

  assign nonempty_w = ~empty_w;
  // Any strobe that no queue accepted (bad id or full target) is a drop.
  assign discard_d  = bus.i_nts_descriptor_wr && (push_w == '0);
  assign arb_start  = (bus.iv_sched_mode == HMS_MODE_SP) ? '0 : rr_q;
  assign arb_sel    = find_first(nonempty_w, arb_start);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= HMS_IDLE;
      desc_q    <= '0;
      wr_q      <= 1'b0;
      ack_q     <= 1'b0;
      discard_q <= 1'b0;
      sel_q     <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      desc_q    <= desc_d;
      wr_q      <= wr_d;
      ack_q     <= ack_d;
      discard_q <= discard_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HMS_IDLE: begin
        if (bus.i_host_outport_free) begin
          if (bus.i_ts_descriptor_wr)  state_d = HMS_HOLD;
          else if (|nonempty_w)        state_d = HMS_NTS_RD;
        end
      end
      HMS_NTS_RD: state_d = HMS_HOLD;
      HMS_HOLD:   state_d = HMS_IDLE;
      default:    state_d = HMS_IDLE;
    endcase
  end

  always_comb begin
    desc_d = desc_q;
    wr_d   = 1'b0;
    ack_d  = 1'b0;
    pop_w  = '0;
    sel_d  = sel_q;
    rr_d   = rr_q;
    case (state_q)
      HMS_IDLE: begin
        if (bus.i_host_outport_free) begin
          if (bus.i_ts_descriptor_wr) begin
            desc_d = bus.iv_ts_descriptor;
            wr_d   = 1'b1;
            ack_d  = 1'b1;
          end else if (|nonempty_w) begin
            pop_w = NUM_NTS_QUEUE'(1) << arb_sel;
            sel_d = arb_sel;
            if (bus.iv_sched_mode == HMS_MODE_RR) rr_d = wrap_inc(arb_sel);
          end
        end
      end
      HMS_NTS_RD: begin
        desc_d = fifo_rdata_w[sel_q];
        wr_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ov_descriptor       = desc_q;
  assign bus.o_descriptor_wr     = wr_q;
  assign bus.o_ts_descriptor_ack = ack_q;
  assign bus.o_nts_discard_pulse = discard_q;
  assign bus.ov_queue_empty      = empty_w;
  assign bus.ov_queue_full       = full_w;
  assign bus.hms_state           = state_q;

endmodule

// File: tb/tb_host_multi_queue_schedule.sv
// Directed bench for host_multi_queue_schedule: reset, NTS/TS issue, RR and
// strict-priority ordering, full/invalid-id drops and mid-operation reset.
module tb_host_multi_queue_schedule;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  host_multi_queue_schedule_if #(.DESC_W(13), .NUM_NTS_QUEUE(4), .QID_W(3)) bus ();

  host_multi_queue_schedule #(
    .DESC_W        (13),
    .NUM_NTS_QUEUE (4),
    .QID_W         (3),
    .FIFO_AW       (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [2:0] id, input logic [12:0] d);
    bus.iv_nts_queue_id     = id;
    bus.iv_nts_descriptor   = d;
    bus.i_nts_descriptor_wr = 1'b1;
    @(negedge clk);
    bus.i_nts_descriptor_wr = 1'b0;
  endtask

  // Waits (bounded) for the next issue strobe; checks data and cycles waited.
  task automatic expect_issue(input string tag, input logic [12:0] d, input int gap);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      n++;
      if (bus.o_descriptor_wr === 1'b1) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_desc"}, 32'(bus.ov_descriptor), 32'(d));
    chk({tag, "_gap"}, 32'(n), 32'(gap));
    $display("issue %s: desc=0x%0h after %0d cycles", tag, bus.ov_descriptor, n);
  endtask

  task automatic load_rr_set();
    enq(3'd0, 13'h100); enq(3'd0, 13'h101);
    enq(3'd1, 13'h110); enq(3'd1, 13'h111);
    enq(3'd3, 13'h130); enq(3'd3, 13'h131);
  endtask

  initial begin
    bit wr_seen;

    rst_n                   = 1'b0;
    bus.iv_sched_mode       = 1'b0;
    bus.iv_nts_descriptor   = '0;
    bus.iv_nts_queue_id     = '0;
    bus.i_nts_descriptor_wr = 1'b0;
    bus.iv_ts_descriptor    = '0;
    bus.i_ts_descriptor_wr  = 1'b0;
    bus.i_host_outport_free = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_desc",    32'(bus.ov_descriptor), 32'h0);
    chk("rst_wr",      32'(bus.o_descriptor_wr), 32'h0);
    chk("rst_ack",     32'(bus.o_ts_descriptor_ack), 32'h0);
    chk("rst_empty",   32'(bus.ov_queue_empty), 32'hF);
    chk("rst_full",    32'(bus.ov_queue_full), 32'h0);
    chk("rst_discard", 32'(bus.o_nts_discard_pulse), 32'h0);
    chk("rst_state",   32'(bus.hms_state), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic NTS issue through q2
    enq(3'd2, 13'h0A5);
    chk("nts_empty_q2", 32'(bus.ov_queue_empty), 32'hB);
    bus.i_host_outport_free = 1'b1;
    @(negedge clk);
    chk("nts_c1_wr",    32'(bus.o_descriptor_wr), 32'h0);
    chk("nts_c1_state", 32'(bus.hms_state), 32'h1);
    chk("nts_c1_empty", 32'(bus.ov_queue_empty), 32'hF);
    @(negedge clk);
    chk("nts_c2_wr",    32'(bus.o_descriptor_wr), 32'h1);
    chk("nts_c2_desc",  32'(bus.ov_descriptor), 32'h0A5);
    chk("nts_c2_state", 32'(bus.hms_state), 32'h2);
    $display("issue nts_basic: desc=0x%0h", bus.ov_descriptor);
    bus.i_host_outport_free = 1'b0;
    @(negedge clk);
    chk("nts_c3_wr",    32'(bus.o_descriptor_wr), 32'h0);
    chk("nts_c3_state", 32'(bus.hms_state), 32'h0);

    // TS beats a waiting NTS descriptor
    enq(3'd0, 13'h001);
    bus.iv_ts_descriptor    = 13'h1FF;
    bus.i_ts_descriptor_wr  = 1'b1;
    bus.i_host_outport_free = 1'b1;
    @(negedge clk);
    chk("ts_wr",   32'(bus.o_descriptor_wr), 32'h1);
    chk("ts_ack",  32'(bus.o_ts_descriptor_ack), 32'h1);
    chk("ts_desc", 32'(bus.ov_descriptor), 32'h1FF);
    $display("issue ts: desc=0x%0h ack=%0b", bus.ov_descriptor, bus.o_ts_descriptor_ack);
    bus.i_ts_descriptor_wr = 1'b0;
    expect_issue("ts_then_q0", 13'h001, 3);
    chk("ts_then_q0_ack", 32'(bus.o_ts_descriptor_ack), 32'h0);
    bus.i_host_outport_free = 1'b0;
    @(negedge clk);

    // Round-robin over q0, q1, q3
    bus.iv_sched_mode = 1'b1;
    load_rr_set();
    bus.i_host_outport_free = 1'b1;
    expect_issue("rr0", 13'h100, 2);
    expect_issue("rr1", 13'h110, 3);
    expect_issue("rr2", 13'h130, 3);
    expect_issue("rr3", 13'h101, 3);
    expect_issue("rr4", 13'h111, 3);
    expect_issue("rr5", 13'h131, 3);
    bus.i_host_outport_free = 1'b0;
    @(negedge clk);
    chk("rr_empty", 32'(bus.ov_queue_empty), 32'hF);

    // Strict priority, same load
    bus.iv_sched_mode = 1'b0;
    load_rr_set();
    bus.i_host_outport_free = 1'b1;
    expect_issue("sp0", 13'h100, 2);
    expect_issue("sp1", 13'h101, 3);
    expect_issue("sp2", 13'h110, 3);
    expect_issue("sp3", 13'h111, 3);
    expect_issue("sp4", 13'h130, 3);
    expect_issue("sp5", 13'h131, 3);
    bus.i_host_outport_free = 1'b0;
    @(negedge clk);
    chk("sp_empty", 32'(bus.ov_queue_empty), 32'hF);

    // Fill q1, overflow once, then an invalid queue id
    for (int i = 0; i < 15; i++) enq(3'd1, 13'(13'h200 + i));
    chk("fill15_full",    32'(bus.ov_queue_full), 32'h0);
    enq(3'd1, 13'h20F);
    chk("fill16_full",    32'(bus.ov_queue_full), 32'h2);
    chk("fill16_empty",   32'(bus.ov_queue_empty), 32'hD);
    chk("fill16_discard", 32'(bus.o_nts_discard_pulse), 32'h0);
    enq(3'd1, 13'h1EE);
    chk("over_discard",   32'(bus.o_nts_discard_pulse), 32'h1);
    $display("enqueue overflow q1: discard=%0b", bus.o_nts_discard_pulse);
    @(negedge clk);
    chk("over_discard_end", 32'(bus.o_nts_discard_pulse), 32'h0);
    enq(3'd5, 13'h055);
    chk("badid_discard", 32'(bus.o_nts_discard_pulse), 32'h1);
    chk("badid_empty",   32'(bus.ov_queue_empty), 32'hD);
    chk("badid_full",    32'(bus.ov_queue_full), 32'h2);
    $display("enqueue bad id 5: discard=%0b", bus.o_nts_discard_pulse);

    // Drain first entry, then reset while the next pop is in NTS_RD
    bus.i_host_outport_free = 1'b1;
    expect_issue("full_head", 13'h200, 2);
    chk("full_after_pop", 32'(bus.ov_queue_full), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_state", 32'(bus.hms_state), 32'h1);
    bus.iv_ts_descriptor   = 13'h0CC;
    bus.i_ts_descriptor_wr = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(bus.hms_state), 32'h0);
    chk("mid_rst_empty", 32'(bus.ov_queue_empty), 32'hF);
    chk("mid_rst_full",  32'(bus.ov_queue_full), 32'h0);
    chk("mid_rst_desc",  32'(bus.ov_descriptor), 32'h0);
    chk("mid_rst_ack",   32'(bus.o_ts_descriptor_ack), 32'h0);
    bus.i_ts_descriptor_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.o_descriptor_wr !== 1'b0) wr_seen = 1'b1;
    end
    chk("post_rst_no_issue", 32'(wr_seen), 32'h0);
    chk("post_rst_empty",    32'(bus.ov_queue_empty), 32'hF);
    $display("reset mid NTS_RD: issues afterwards=%0b", wr_seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
